fab_clk_lock_sequencer: RTL

//  Fabric-side consumer of the MSS CCC clock output. Qualifies the CCC lock

---
 rtl/fab_clk_pkg.sv | 20 ++
 rtl/fab_sync2.sv | 24 ++
 rtl/fab_clk_lock_sequencer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/fab_clk_pkg.sv
// Shared types and constants for the fabric clock-lock reset sequencer.
// Holds the FSM state encoding and the saturating lock-loss counter helper.
package fab_clk_pkg;

    localparam int LOSS_CNT_W = 8;
    localparam int STATE_W    = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_QUALIFY   = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3,
        ST_HOLD      = 3'd4
    } seq_state_e;

    function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] value);
        return (value == '1) ? value : value + LOSS_CNT_W'(1);
    endfunction

endpackage

// File: rtl/fab_sync2.sv
// Two-flop synchroniser for asynchronous CCC status bits into the fabric clock.
// Both flops clear on reset, so the synchronised output starts low.
module fab_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/fab_clk_lock_sequencer.sv
// Qualifies CCC lock, releases staged fabric resets, and re-sequences after
// lock loss or a software request with a minimum all-reset hold time.
//
//  state      | meaning
//  WAIT_LOCK  | resets held, waiting for synchronised lock
//  QUALIFY    | counting consecutive lock-high cycles
//  RELEASE    | releasing reset bits one per STAGE_GAP cycles
//  RUN        | all resets released, READY high
//  HOLD       | all resets asserted for at least HOLD_CYCLES after a fault
module fab_clk_lock_sequencer
    import fab_clk_pkg::*;
#(
    parameter int N_STAGES           = 3,
    parameter int LOCK_STABLE_CYCLES = 16,
    parameter int STAGE_GAP          = 4,
    parameter int HOLD_CYCLES        = 8,
    parameter bit LOCK_BYPASS        = 1'b0
) (
    input  logic                  fab_clk,
    input  logic                  m2f_reset_n,
    input  logic                  lock_in,
    input  logic                  sw_rst_req,
    output logic [N_STAGES-1:0]   rst_n_out,
    output logic                  ready,
    output logic [LOSS_CNT_W-1:0] loss_cnt,
    output logic [STATE_W-1:0]    state
);

    localparam int QUAL_W  = $clog2(LOCK_STABLE_CYCLES) + 1;
    localparam int GAP_W   = $clog2(STAGE_GAP) + 1;
    localparam int IDX_W   = $clog2(N_STAGES) + 1;
    localparam int HOLD_W  = $clog2(HOLD_CYCLES) + 1;

    localparam logic [QUAL_W-1:0]   QUAL_LAST  = QUAL_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [GAP_W-1:0]    GAP_LAST   = GAP_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(N_STAGES - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [N_STAGES-1:0] STAGE_ONE  = N_STAGES'(1);

    seq_state_e          state_q;
    seq_state_e          state_d;
    logic                lock_src;
    logic                lock_s;
    logic                fault_run;

    logic [QUAL_W-1:0]   qual_cnt;
    logic [QUAL_W-1:0]   qual_d;
    logic [GAP_W-1:0]    stage_cnt;
    logic [GAP_W-1:0]    stage_cnt_d;
    logic [IDX_W-1:0]    stage_idx;
    logic [IDX_W-1:0]    stage_idx_d;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   hold_d;
    logic [N_STAGES-1:0] rst_d;
    logic                ready_d;
    logic                loss_inc;

    // Bypass drives the synchroniser input so lock latency matches a real lock.
    assign lock_src = LOCK_BYPASS ? 1'b1 : lock_in;

    fab_sync2 #(.W(1)) u_lock_sync (
        .clk   (fab_clk),
        .rst_n (m2f_reset_n),
        .d     (lock_src),
        .q     (lock_s)
    );

    assign fault_run = !lock_s || sw_rst_req;
    assign state     = state_q;

    always_ff @(posedge fab_clk or negedge m2f_reset_n) begin
        if (!m2f_reset_n) state_q <= ST_WAIT_LOCK;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_LOCK: begin
                if (sw_rst_req)  state_d = ST_HOLD;
                else if (lock_s) state_d = ST_QUALIFY;
            end
            ST_QUALIFY: begin
                if (sw_rst_req)             state_d = ST_HOLD;
                else if (!lock_s)           state_d = ST_WAIT_LOCK;
                else if (qual_cnt == QUAL_LAST)
                    state_d = (N_STAGES == 1) ? ST_RUN : ST_RELEASE;
            end
            ST_RELEASE: begin
                if (fault_run) state_d = ST_HOLD;
                else if (stage_cnt == GAP_LAST && stage_idx == IDX_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (fault_run) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (hold_cnt == HOLD_LAST && !sw_rst_req) state_d = ST_WAIT_LOCK;
            end
            default: state_d = ST_WAIT_LOCK;
        endcase
    end

    always_comb begin
        rst_d       = rst_n_out;
        ready_d     = ready;
        loss_inc    = 1'b0;
        qual_d      = qual_cnt;
        stage_cnt_d = stage_cnt;
        stage_idx_d = stage_idx;
        hold_d      = hold_cnt;
        case (state_q)
            ST_WAIT_LOCK: qual_d = '0;
            ST_QUALIFY: begin
                if (state_d == ST_QUALIFY) begin
                    qual_d = qual_cnt + 1'b1;
                end else if (state_d == ST_RELEASE || state_d == ST_RUN) begin
                    rst_d[0]    = 1'b1;
                    stage_cnt_d = '0;
                    stage_idx_d = IDX_W'(1);
                    ready_d     = (state_d == ST_RUN);
                end
            end
            ST_RELEASE: begin
                if (state_d == ST_RELEASE || state_d == ST_RUN) begin
                    if (stage_cnt == GAP_LAST) begin
                        rst_d       = rst_n_out | (STAGE_ONE << stage_idx);
                        stage_cnt_d = '0;
                        stage_idx_d = stage_idx + 1'b1;
                        ready_d     = (state_d == ST_RUN);
                    end else begin
                        stage_cnt_d = stage_cnt + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (hold_cnt != HOLD_LAST) hold_d = hold_cnt + 1'b1;
            end
            ST_RUN: ;
            default: begin
                rst_d   = '0;
                ready_d = 1'b0;
            end
        endcase
        // Fault entry overrides everything; only a lost lock counts as a loss event.
        if (state_d == ST_HOLD && state_q != ST_HOLD) begin
            rst_d    = '0;
            ready_d  = 1'b0;
            hold_d   = '0;
            loss_inc = !lock_s && (state_q == ST_RELEASE || state_q == ST_RUN);
        end
    end

    always_ff @(posedge fab_clk or negedge m2f_reset_n) begin
        if (!m2f_reset_n) begin
            qual_cnt  <= '0;
            stage_cnt <= '0;
            stage_idx <= '0;
            hold_cnt  <= '0;
        end else begin
            qual_cnt  <= qual_d;
            stage_cnt <= stage_cnt_d;
            stage_idx <= stage_idx_d;
            hold_cnt  <= hold_d;
        end
    end

    always_ff @(posedge fab_clk or negedge m2f_reset_n) begin
        if (!m2f_reset_n) begin
            rst_n_out <= '0;
            ready     <= 1'b0;
            loss_cnt  <= '0;
        end else begin
            rst_n_out <= rst_d;
            ready     <= ready_d;
            if (loss_inc) loss_cnt <= sat_inc(loss_cnt);
        end
    end

endmodule
